gpr_regfile: RTL and testbench
==============================

Name: gpr_regfile

Overview:
- General-purpose register file with write-back sink and scoreboard. It sits between the decode/execute units and the write-back path.
- Accepts execute-stage writes (enable, address, data) through a valid/ready handshake and serves two combinational read ports.
- Tracks per-register pending-write (busy) bits so decode can stall on RAW hazards.
- After reset, runs a clear sequencer that zeroes every register before it accepts writes.

Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_valid  input  1  execute stage presents a write.
- wb_ready  output  1  register file can accept a write this cycle.
- wb_addr  input  ADDR_WIDTH  destination register.
- wb_data  input  DATA_WIDTH  write data.
- issue_valid  input  1  decode issues an instruction that will write issue_addr.
- issue_addr  input  ADDR_WIDTH  destination to mark busy.
- raddr1, raddr2  input  ADDR_WIDTH  read addresses.
- rdata1, rdata2  output  DATA_WIDTH  read data.
- rbusy1, rbusy2  output  1  the addressed register has a pending write.
- init_done  output  1  the clear sequence is complete.

Behaviour:
- Reset values:
  - state=CLEAR, clr_idx=0, all busy bits=0.
  - wb_ready=0, init_done=0.
  - rdata1/2=0 and rbusy1/2=0 while in CLEAR.
- State CLEAR:
  - Each cycle writes regs[clr_idx]=0 and increments clr_idx.
  - When clr_idx == 2**ADDR_WIDTH-1, the final entry is zeroed and the next state is RUN.
  - CLEAR lasts exactly 2**ADDR_WIDTH cycles after rst deasserts.
  - wb_ready=0 throughout; issue_valid is ignored.
- State RUN:
  - wb_ready=1 and init_done=1. RUN is left only via rst.
  - Asserting rst in any state, including mid-clear, restarts CLEAR from index 0.
- Write handshake:
  - A transfer occurs on a rising edge with wb_valid && wb_ready.
  - regs[wb_addr] <= wb_data, except that a write to address 0 is accepted and discarded.
  - The result is visible on the read ports the cycle after the edge.
  - wb_ready does not depend on wb_valid (no combinational loop).
- Read:
  - Combinational. Address 0 always returns 0 and rbusy=0.
- Scoreboard:
  - issue_valid in RUN sets busy[issue_addr]; an accepted write clears busy[wb_addr].
  - Same edge, same address, set and clear together: set wins (the newer writer is outstanding).
  - Same edge, different addresses: both take effect.
  - busy[0] is never set.
  - A write to a non-busy register is legal and leaves its busy bit 0.
- Width rules: no arithmetic on data; clr_idx is ADDR_WIDTH bits and does not wrap in RUN.

Optional Feature:
- Macro GPR_REGFILE_BYPASS_EN.
- Defined: when a write is accepted this cycle and raddrN == wb_addr != 0:
  - rdataN = wb_data, combinational same-cycle forward.
  - rbusyN = 0, unless issue_valid re-marks the same address this cycle.
- Undefined: no forwarding; the reader sees the new value and the cleared busy bit one cycle after the write edge.
- Both builds must pass the same tests, with the bypass scenario expectations selected by the macro.

Decomposition:
- Shared package holds:
  - constant REG_ZERO = 0;
  - typedef reg_addr_t [ADDR_WIDTH-1:0];
  - typedef reg_data_t [DATA_WIDTH-1:0];
  - enum regfile_state_t {CLEAR, RUN}.
- One natural sub-module, gpr_scoreboard: holds the busy vector and implements set/clear priority and the rbusy lookups.
- Storage array, clear sequencer and read muxes stay in gpr_regfile.

Test Plan:
- Reset then clear: pulse rst 1 cycle, then deassert.
  - wb_ready=0 and init_done=0 for exactly 32 cycles, then both 1.
  - Reading any raddr 1..31 returns 0.
- Basic write: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF for one cycle; raddr1=5 next cycle -> rdata1=0xDEADBEEF.
- x0 protection: write addr 0 data 0x12345678 -> rdata1 at raddr1=0 stays 0; issue_valid addr 0 -> rbusy1 stays 0.
- Scoreboard race:
  - issue_valid addr 7, then next cycle an accepted write to 7 with issue_valid addr 7 on the same edge -> rbusy=1 after that edge.
  - A further write to 7 with no issue -> rbusy=0.
- Reset mid-clear: assert rst at clear cycle 10, release -> init_done rises exactly 32 cycles after release, and all registers read 0.
- Bypass: write addr 3 data 0xA5A5A5A5 with raddr2=3 in the same cycle.
  - With GPR_REGFILE_BYPASS_EN: rdata2=0xA5A5A5A5 that cycle.
  - Without it: old value that cycle, new value the next cycle.

Source files
------------

// File: rtl/gpr_regfile_pkg.sv
// Shared definitions for the general-purpose register file.
//   ADDR_WIDTH / DATA_WIDTH : register index and data widths
//   reg_addr_t / reg_data_t : address and data types
//   REG_ZERO                : hard-wired zero register index
//   regfile_state_t         : CLEAR (post-reset zeroing) / RUN
package gpr_regfile_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;
  localparam reg_addr_t LAST_IDX = reg_addr_t'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_t;
endpackage

// File: rtl/gpr_regfile_if.sv
// Bus between the execute/decode stages and the register file.
//   wb_*     : write-back handshake (valid/ready, address, data)
//   issue_*  : destination marking for the hazard scoreboard
//   raddrN / rdataN / rbusyN : two combinational read ports
//   init_done: post-reset clear sequence finished
// master = pipeline side, slave = register file.
interface gpr_regfile_if;
  import gpr_regfile_pkg::*;

  logic      wb_valid;
  logic      wb_ready;
  reg_addr_t wb_addr;
  reg_data_t wb_data;
  logic      issue_valid;
  reg_addr_t issue_addr;
  reg_addr_t raddr1;
  reg_addr_t raddr2;
  reg_data_t rdata1;
  reg_data_t rdata2;
  logic      rbusy1;
  logic      rbusy2;
  logic      init_done;

  modport master (
    output wb_valid, wb_addr, wb_data, issue_valid, issue_addr, raddr1, raddr2,
    input  wb_ready, rdata1, rdata2, rbusy1, rbusy2, init_done
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, issue_valid, issue_addr, raddr1, raddr2,
    output wb_ready, rdata1, rdata2, rbusy1, rbusy2, init_done
  );
endinterface

// File: rtl/gpr_regfile_scoreboard.sv
// Pending-write (busy) tracker for RAW hazard stalls.
//   clk, rst    : clock, synchronous active-high reset
//   i_set_*     : mark a destination busy (issue)
//   i_clr_*     : clear busy on an accepted write-back
//   i_raddrN    : lookup addresses; o_busyN : busy flags
// Optional macro GPR_REGFILE_BYPASS_EN forwards the same-cycle clear to
// the lookups.
module gpr_scoreboard
  import gpr_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_set_en,
  input  reg_addr_t i_set_addr,
  input  logic      i_clr_en,
  input  reg_addr_t i_clr_addr,
  input  reg_addr_t i_raddr1,
  input  reg_addr_t i_raddr2,
  output logic      o_busy1,
  output logic      o_busy2
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  // Register 0 can never be marked, so its busy bit stays 0.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (i_set_en && (i_set_addr != REG_ZERO)) w_set_vec[i_set_addr] = 1'b1;
    if (i_clr_en) w_clr_vec[i_clr_addr] = 1'b1;
  end

  // Set is applied after clear: a newer writer to the same register
  // remains outstanding.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
  end

  always_comb begin
    o_busy1 = r_busy[i_raddr1];
    o_busy2 = r_busy[i_raddr2];
`ifdef GPR_REGFILE_BYPASS_EN
    if (i_clr_en && (i_raddr1 == i_clr_addr) && (i_raddr1 != REG_ZERO))
      o_busy1 = w_set_vec[i_raddr1];
    if (i_clr_en && (i_raddr2 == i_clr_addr) && (i_raddr2 != REG_ZERO))
      o_busy2 = w_set_vec[i_raddr2];
`endif
  end
endmodule

// File: rtl/gpr_regfile.sv
// General-purpose register file with write-back sink and busy scoreboard.
//   clk, rst : clock, synchronous active-high reset
//   s_bus    : gpr_regfile_if.slave (write-back, issue, two read ports,
//              init_done)
// After reset every register is zeroed one per cycle before writes are
// accepted. Optional macro GPR_REGFILE_BYPASS_EN adds same-cycle
// write-to-read forwarding.
//
// state | meaning
// CLEAR | zeroing regs[clr_idx], writes and issues ignored
// RUN   | accepting writes, scoreboard active
module gpr_regfile
  import gpr_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  gpr_regfile_if.slave  s_bus
);
  regfile_state_t r_state;
  regfile_state_t w_next_state;
  reg_addr_t      r_clr_idx;
  reg_data_t      r_regs [NUM_REGS];
  logic           w_clear_en;
  logic           w_wb_ready;
  logic           w_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_clear_en) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_clear_en   = 1'b0;
    w_wb_ready   = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clear_en = 1'b1;
        if (r_clr_idx == LAST_IDX) w_next_state = RUN;
      end
      RUN:     w_wb_ready = 1'b1;
      default: w_next_state = CLEAR;
    endcase
  end

  assign w_wr_en          = s_bus.wb_valid && w_wb_ready;
  assign s_bus.wb_ready   = w_wb_ready;
  assign s_bus.init_done  = (r_state == RUN);

  // Storage has no reset of its own; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (w_clear_en)
      r_regs[r_clr_idx] <= '0;
    else if (w_wr_en && (s_bus.wb_addr != REG_ZERO))
      r_regs[s_bus.wb_addr] <= s_bus.wb_data;
  end

  always_comb begin
    s_bus.rdata1 = '0;
    s_bus.rdata2 = '0;
    if (r_state == RUN) begin
      if (s_bus.raddr1 != REG_ZERO) s_bus.rdata1 = r_regs[s_bus.raddr1];
      if (s_bus.raddr2 != REG_ZERO) s_bus.rdata2 = r_regs[s_bus.raddr2];
`ifdef GPR_REGFILE_BYPASS_EN
      if (w_wr_en && (s_bus.raddr1 == s_bus.wb_addr) && (s_bus.raddr1 != REG_ZERO))
        s_bus.rdata1 = s_bus.wb_data;
      if (w_wr_en && (s_bus.raddr2 == s_bus.wb_addr) && (s_bus.raddr2 != REG_ZERO))
        s_bus.rdata2 = s_bus.wb_data;
`endif
    end
  end

  // Busy bits are all 0 during CLEAR (reset clears them, issue is gated),
  // so the lookups need no extra state gating.
  gpr_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (s_bus.issue_valid && (r_state == RUN)),
    .i_set_addr (s_bus.issue_addr),
    .i_clr_en   (w_wr_en),
    .i_clr_addr (s_bus.wb_addr),
    .i_raddr1   (s_bus.raddr1),
    .i_raddr2   (s_bus.raddr2),
    .o_busy1    (s_bus.rbusy1),
    .o_busy2    (s_bus.rbusy2)
  );
endmodule

// File: tb/tb_gpr_regfile.sv
module tb_gpr_regfile;
  import gpr_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpr_regfile_if bus();

  gpr_regfile dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: array contents, busy flags, cycles since reset release.
  reg_data_t m_regs [NUM_REGS];
  bit        m_busy [NUM_REGS];
  int        m_clr_cnt;

  task automatic chk_data(input string tag, input reg_data_t obs, input reg_data_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit m_run();
    return m_clr_cnt >= NUM_REGS;
  endfunction

  function automatic reg_data_t exp_rdata(input reg_addr_t ra);
    if (!m_run() || ra == 0) return '0;
`ifdef GPR_REGFILE_BYPASS_EN
    if (bus.wb_valid && bus.wb_addr == ra) return bus.wb_data;
`endif
    return m_regs[ra];
  endfunction

  function automatic logic exp_rbusy(input reg_addr_t ra);
    if (!m_run() || ra == 0) return 1'b0;
`ifdef GPR_REGFILE_BYPASS_EN
    if (bus.wb_valid && bus.wb_addr == ra)
      return bus.issue_valid && bus.issue_addr == ra;
`endif
    return m_busy[ra];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_clr_cnt = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else if (!m_run()) begin
      m_clr_cnt++;
    end else begin
      if (bus.wb_valid) begin
        if (bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (bus.issue_valid && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance one edge.
  task automatic step(input logic r, input logic wv, input reg_addr_t wa,
                      input reg_data_t wd, input logic iv, input reg_addr_t ia,
                      input reg_addr_t ra1, input reg_addr_t ra2, input string tag);
    rst             = r;
    bus.wb_valid    = wv;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    bus.issue_valid = iv;
    bus.issue_addr  = ia;
    bus.raddr1      = ra1;
    bus.raddr2      = ra2;
    #4;
    chk_bit ({tag, "_wb_ready"},  bus.wb_ready,  m_run());
    chk_bit ({tag, "_init_done"}, bus.init_done, m_run());
    chk_data({tag, "_rdata1"},    bus.rdata1,    exp_rdata(ra1));
    chk_data({tag, "_rdata2"},    bus.rdata2,    exp_rdata(ra2));
    chk_bit ({tag, "_rbusy1"},    bus.rbusy1,    exp_rbusy(ra1));
    chk_bit ({tag, "_rbusy2"},    bus.rbusy2,    exp_rbusy(ra2));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic reg_addr_t rand_addr();
    return reg_addr_t'($urandom_range(NUM_REGS - 1));
  endfunction

  task automatic rand_step(input string tag);
    step(1'b0, 1'($urandom_range(1)), rand_addr(), reg_data_t'($urandom),
         1'($urandom_range(1)), rand_addr(), rand_addr(), rand_addr(), tag);
  endtask

  task automatic read_step(input reg_addr_t a, input string tag);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, a, a, tag);
  endtask

  initial begin
    rst             = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.raddr1      = '0;
    bus.raddr2      = '0;
    m_clr_cnt       = 0;
    @(posedge clk);
    model_edge();
    #1;

    // Clear phase with random (ignored) traffic; ready must stay low 32 cycles.
    for (int i = 0; i < NUM_REGS + 2; i++) rand_step("clear");
    for (int a = 1; a < NUM_REGS; a++) read_step(reg_addr_t'(a), "sweep0");

    // Basic write and read-back.
    step(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 0, "wr5");
    read_step(5, "rd5");

    // Register 0 protection.
    step(1'b0, 1'b1, 0, 32'h12345678, 1'b0, 0, 0, 0, "wr0");
    read_step(0, "rd0");
    step(1'b0, 1'b0, 0, 0, 1'b1, 0, 0, 0, "iss0");
    read_step(0, "busy0");

    // Scoreboard race on register 7.
    step(1'b0, 1'b0, 0, 0, 1'b1, 7, 7, 7, "iss7");
    step(1'b0, 1'b1, 7, 32'h00000077, 1'b1, 7, 7, 7, "race7");
    read_step(7, "busy7_set");
    step(1'b0, 1'b1, 7, 32'h00000777, 1'b0, 0, 7, 7, "wr7");
    read_step(7, "busy7_clr");

    // Different-address set and clear on the same edge.
    step(1'b0, 1'b0, 0, 0, 1'b1, 9, 9, 10, "iss9");
    step(1'b0, 1'b1, 9, 32'h99999999, 1'b1, 10, 9, 10, "mix");
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 9, 10, "mix_rd");

    // Write-to-read bypass on register 3.
    step(1'b0, 1'b1, 3, 32'h11111111, 1'b0, 0, 0, 0, "pre3");
    step(1'b0, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, 0, 3, "byp3");
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 3, "byp3_next");

    for (int i = 0; i < 400; i++) rand_step("rand");

    // Reset from RUN, then again at clear cycle 10.
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 5, 3, "rst_run");
    for (int i = 0; i < 10; i++) rand_step("clear1");
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 5, 3, "rst_mid");
    for (int i = 0; i < NUM_REGS + 1; i++) rand_step("clear2");
    for (int a = 0; a < NUM_REGS; a++) read_step(reg_addr_t'(a), "sweep1");

    for (int i = 0; i < 200; i++) rand_step("rand2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
